regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_merge.sv | 29 ++
 rtl/regfile_mp.sv | 108 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared encodings for the multi-port register file: write modes, FSM states
// and the link return-address offset.
package regfile_pkg;

    typedef enum logic [1:0] {
        MODE_WORD  = 2'd0,
        MODE_HALF  = 2'd1,
        MODE_BYTE  = 2'd2,
        MODE_UPPER = 2'd3
    } wr_mode_e;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int LINK_OFFSET = 4;

endpackage

// File: rtl/regfile_merge.sv
// Combines a register's old contents with new write data according to the
// write mode; shared by the register write path and the read bypass.
module regfile_merge
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] old_val,
    input  logic [DATA_W-1:0] new_val,
    output logic [DATA_W-1:0] merged
);

    localparam logic [DATA_W-1:0] HALF_MASK = DATA_W'(16'hFFFF);
    localparam logic [DATA_W-1:0] BYTE_MASK = DATA_W'(8'hFF);

    // Partial modes keep the old upper bits; upper-immediate zero-fills below.
    always_comb begin
        merged = new_val;
        case (wr_mode_e'(mode))
            MODE_WORD:  merged = new_val;
            MODE_HALF:  merged = (old_val & ~HALF_MASK) | (new_val & HALF_MASK);
            MODE_BYTE:  merged = (old_val & ~BYTE_MASK) | (new_val & BYTE_MASK);
            MODE_UPPER: merged = (new_val & HALF_MASK) << (DATA_W - 16);
            default:    merged = new_val;
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with partial writes, link writes and a
// power-up clear sequence. Define REGFILE_BYPASS_EN for write-to-read bypass.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int LINK_REG = 31
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD-1:0]        rd_en,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [1:0]              wr_mode,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    link_en,
    input  logic [DATA_W-1:0]       link_pc,
    output logic                    ready
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] regs [DEPTH];
    state_e            state, next_state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] link_val;
    logic              do_wr, do_link;
    logic [ADDR_W-1:0] rd_idx  [NREAD];
    logic [DATA_W-1:0] rd_next [NREAD];

    assign ready    = (state == RUN);
    assign link_val = link_pc + DATA_W'(LINK_OFFSET);
    assign do_link  = ready && link_en && (LINK_ADDR != '0);
    // A link write to the same register wins over the ordinary write.
    assign do_wr    = ready && wr_en && (wr_addr != '0)
                      && !(do_link && (wr_addr == LINK_ADDR));

    regfile_merge #(.DATA_W(DATA_W)) u_merge (
        .mode    (wr_mode),
        .old_val (regs[wr_addr]),
        .new_val (wr_data),
        .merged  (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        if (state == CLEAR && clr_cnt == LAST_ADDR)
            next_state = RUN;
    end

    // Storage has no reset; the clear sequence zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            regs[clr_cnt] <= '0;
        end else begin
            if (do_wr)
                regs[wr_addr] <= merged;
            if (do_link)
                regs[LINK_ADDR] <= link_val;
        end
    end

    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            rd_idx[i]  = rd_addr[i*ADDR_W +: ADDR_W];
            rd_next[i] = regs[rd_idx[i]];
`ifdef REGFILE_BYPASS_EN
            if (do_link && rd_idx[i] == LINK_ADDR)
                rd_next[i] = link_val;
            else if (do_wr && rd_idx[i] == wr_addr)
                rd_next[i] = merged;
`endif
            if (rd_idx[i] == '0)
                rd_next[i] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (state == CLEAR) begin
            rd_data <= '0;
        end else begin
            for (int i = 0; i < NREAD; i++)
                if (rd_en[i])
                    rd_data[i*DATA_W +: DATA_W] <= rd_next[i];
        end
    end

endmodule
